// File: rtl/calc_pkg.sv
// Shared encodings for the calculator entry controller: key codes, ALU
// operation codes and FSM state values.
package calc_pkg;

  localparam logic [3:0] KEY_ADD    = 4'd10;
  localparam logic [3:0] KEY_SUB    = 4'd11;
  localparam logic [3:0] KEY_MUL    = 4'd12;
  localparam logic [3:0] KEY_EQUAL  = 4'd13;
  localparam logic [3:0] KEY_CLEAR  = 4'd14;
  localparam logic [3:0] KEY_IGNORE = 4'd15;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;

  localparam logic [2:0] S_A    = 3'd0;
  localparam logic [2:0] S_B    = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_RES  = 3'd3;

  function automatic logic isDigit(input logic [3:0] key);
    return key <= 4'd9;
  endfunction

  function automatic logic isOperator(input logic [3:0] key);
    return (key == KEY_ADD) || (key == KEY_SUB) || (key == KEY_MUL);
  endfunction

  function automatic logic [1:0] keyToOp(input logic [3:0] key);
    logic [1:0] op;
    case (key)
      KEY_SUB: op = OP_SUB;
      KEY_MUL: op = OP_MUL;
      default: op = OP_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Keypad debouncer: a press or release must be stable for DEBOUNCE_CYCLES
// cycles; each accepted press yields a single one-cycle key_event_o.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] col_i,
  input  logic [3:0] key_code_i,
  output logic       key_event_o,
  output logic [3:0] key_code_o
);

  localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          rawPressed;
  logic          pressed_q, pressed_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          keyEvent_q, keyEvent_d;
  logic [3:0]    keyCode_q, keyCode_d;

  assign rawPressed = ~&col_i;

  // The counter only runs while the raw level disagrees with the accepted
  // level, so a press is accepted once and a release must be seen before the next.
  always_comb begin
    pressed_d  = pressed_q;
    cnt_d      = '0;
    keyEvent_d = 1'b0;
    keyCode_d  = keyCode_q;
    if (rawPressed != pressed_q) begin
      if (cnt_q == LAST) begin
        pressed_d = rawPressed;
        if (rawPressed) begin
          keyEvent_d = 1'b1;
          keyCode_d  = key_code_i;
        end
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pressed_q  <= 1'b0;
      cnt_q      <= '0;
      keyEvent_q <= 1'b0;
      keyCode_q  <= 4'd0;
    end else begin
      pressed_q  <= pressed_d;
      cnt_q      <= cnt_d;
      keyEvent_q <= keyEvent_d;
      keyCode_q  <= keyCode_d;
    end
  end

  assign key_event_o = keyEvent_q;
  assign key_code_o  = keyCode_q;

endmodule

// File: rtl/calc_entry_ctrl.sv
// Calculator entry controller: collects two decimal operands and an operator
// from a debounced keypad, hands them to an external ALU and shows the result.
module calc_entry_ctrl
  import calc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int MAX_DIGITS      = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  Col,
  input  logic [3:0]  key_code,
  output logic        alu_req,
  output logic [1:0]  alu_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic        alu_done,
  input  logic [31:0] alu_result,
  output logic [31:0] display,
  output logic [2:0]  state_o
);

  localparam int DW = $clog2(MAX_DIGITS + 1);
  localparam logic [DW-1:0] DIGIT_LIMIT = DW'(MAX_DIGITS);

  logic          keyEvent;
  logic [3:0]    keyCode;

  logic [2:0]    state_q, state_d;
  logic [31:0]   accA_q, accA_d;
  logic [31:0]   accB_q, accB_d;
  logic [DW-1:0] cntA_q, cntA_d;
  logic [DW-1:0] cntB_q, cntB_d;
  logic [1:0]    op_q, op_d;
  logic          req_q, req_d;
  logic [31:0]   result_q, result_d;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk        (clk),
    .rst_n      (rst_n),
    .col_i      (Col),
    .key_code_i (key_code),
    .key_event_o(keyEvent),
    .key_code_o (keyCode)
  );

  // Clear is checked first so it beats a same-cycle alu_done.
  always_comb begin
    state_d  = state_q;
    accA_d   = accA_q;
    accB_d   = accB_q;
    cntA_d   = cntA_q;
    cntB_d   = cntB_q;
    op_d     = op_q;
    req_d    = req_q;
    result_d = result_q;
    if (keyEvent && keyCode == KEY_CLEAR) begin
      state_d = S_A;
      accA_d  = '0;
      accB_d  = '0;
      cntA_d  = '0;
      cntB_d  = '0;
      req_d   = 1'b0;
    end else begin
      case (state_q)
        S_A: begin
          if (keyEvent && isDigit(keyCode) && cntA_q < DIGIT_LIMIT) begin
            accA_d = accA_q * 32'd10 + 32'(keyCode);
            cntA_d = cntA_q + DW'(1);
          end else if (keyEvent && isOperator(keyCode)) begin
            op_d    = keyToOp(keyCode);
            accB_d  = '0;
            cntB_d  = '0;
            state_d = S_B;
          end
        end
        S_B: begin
          if (keyEvent && isDigit(keyCode) && cntB_q < DIGIT_LIMIT) begin
            accB_d = accB_q * 32'd10 + 32'(keyCode);
            cntB_d = cntB_q + DW'(1);
          end else if (keyEvent && keyCode == KEY_EQUAL && cntB_q != '0) begin
            req_d   = 1'b1;
            state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          if (alu_done) begin
            result_d = alu_result;
            req_d    = 1'b0;
            state_d  = S_RES;
          end
        end
        S_RES: begin
          if (keyEvent && isDigit(keyCode)) begin
            accA_d  = 32'(keyCode);
            cntA_d  = DW'(1);
            state_d = S_A;
          end else if (keyEvent && isOperator(keyCode)) begin
            accA_d  = result_q;
            op_d    = keyToOp(keyCode);
            accB_d  = '0;
            cntB_d  = '0;
            state_d = S_B;
          end
        end
        default: state_d = S_A;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_A;
      accA_q   <= '0;
      accB_q   <= '0;
      cntA_q   <= '0;
      cntB_q   <= '0;
      op_q     <= OP_ADD;
      req_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      accA_q   <= accA_d;
      accB_q   <= accB_d;
      cntA_q   <= cntA_d;
      cntB_q   <= cntB_d;
      op_q     <= op_d;
      req_q    <= req_d;
      result_q <= result_d;
    end
  end

  // While entering B, A stays on screen until the first B digit arrives.
  always_comb begin
    case (state_q)
      S_A:     display = accA_q;
      S_B:     display = (cntB_q == '0) ? accA_q : accB_q;
      S_WAIT:  display = accB_q;
      S_RES:   display = result_q;
      default: display = accA_q;
    endcase
  end

  assign alu_req = req_q;
  assign alu_op  = op_q;
  assign alu_a   = accA_q;
  assign alu_b   = accB_q;
  assign state_o = state_q;

endmodule
